code_guess_evaluator: RTL
=========================

Name: code_guess_evaluator

Overview:
Sequential successor to the 4-digit code comparator in the code-break game. Holds a loaded defusal code of NUM_DIGITS digits, each DIGIT_W wide. Scores each submitted guess over several cycles, returning exact matches (right digit, right place) and partial matches (right digit, wrong place). Tracks the attempt count, with solved and lockout status. Sits between the PMOD input capture logic and the SSD and display controller.

Parameters:
NUM_DIGITS, 4, number of digits in code and guess
DIGIT_W, 4, bits per digit
DIGIT_MAX, 9, largest legal digit value (DIGIT_MAX < 2**DIGIT_W)
MAX_ATTEMPTS, 10, guesses allowed before lockout; 0 = unlimited
Derived (localparam): CNT_W = $clog2(NUM_DIGITS+1); ATT_W = $clog2(MAX_ATTEMPTS+1), min 1; VEC_W = NUM_DIGITS*DIGIT_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
code_load  in  1  one-cycle strobe: load code_in
code_in  in  VEC_W  code; digit i = [i*DIGIT_W +: DIGIT_W], digit NUM_DIGITS-1 is the MSB digit
guess_valid  in  1  guess offered
guess_ready  out  1  block can accept a guess
guess_in  in  VEC_W  guess, same packing as code_in
result_valid  out  1  one-cycle pulse: result fields valid
exact_cnt  out  CNT_W  exact matches of last scored guess
partial_cnt  out  CNT_W  partial matches of last scored guess
guess_err  out  1  last guess rejected (illegal digit)
code_err  out  1  one-cycle pulse: code_load rejected
solved  out  1  sticky: code found
locked_out  out  1  sticky: attempts exhausted
attempts_used  out  ATT_W  attempts consumed since last code load

Behaviour:
- One clock domain. Reset is asynchronous and active-low. All outputs are registered.
- Reset values: all outputs 0; state NO_CODE; stored code 0.
- States:
  - NO_CODE: guess_ready=0.
  - READY: guess_ready=1.
  - EXACT, TOTAL, RESULT, REJECT: guess_ready=0.
  - DONE and LOCKED: guess_ready=0.
- Accept: a guess is accepted at the edge where guess_valid && guess_ready. guess_in is latched at that edge; the source may change it afterwards.
- Illegal guess (any digit > DIGIT_MAX):
  - The block goes to REJECT.
  - At the next edge: result_valid=1, guess_err=1, exact_cnt=partial_cnt=0; attempts unchanged.
  - Then back to READY.
- Legal guess: guess_err is cleared at the accept edge, attempts_used increments at the accept edge, then the block goes to EXACT.
- EXACT: lasts NUM_DIGITS cycles. Compares one digit position per cycle (index 0 upward) and accumulates the exact count.
- TOTAL: lasts DIGIT_MAX+1 cycles, one digit value v per cycle starting from v=0. Adds min(count of v in code, count of v in guess) to the total.
- RESULT: entered at edge NUM_DIGITS+DIGIT_MAX+1 after the accept edge (14 with defaults).
  - result_valid=1 for exactly one cycle.
  - exact_cnt=exact; partial_cnt=total-exact. The subtraction never underflows because total ≥ exact.
  - exact_cnt and partial_cnt hold until the next result.
- Leaving RESULT:
  - exact==NUM_DIGITS: set solved, go to DONE.
  - Otherwise, MAX_ATTEMPTS≠0 and attempts_used==MAX_ATTEMPTS: set locked_out, go to LOCKED.
  - Otherwise: go to READY.
- code_load: has priority in every state, including mid-evaluation.
  - Legal code: store it; clear solved, locked_out, attempts_used and guess_err; go to READY. Any in-flight evaluation is aborted with no result_valid.
  - Code with an illegal digit: ignored (state and code unchanged), code_err pulses for one cycle.
- code_load and guess_valid in the same cycle: code_load wins and the guess is not accepted.
- attempts_used saturates at MAX_ATTEMPTS. With MAX_ATTEMPTS=0 it saturates at all-ones and lockout never occurs.
- Duplicate digits in code or guess are scored by the histogram rule: each code digit matches at most once.
- An asynchronous reset mid-evaluation returns the block to NO_CODE and discards the stored code.

Decomposition:
- Package code_break_pkg holds:
  - the state enum (NO_CODE, READY, EXACT, TOTAL, RESULT, REJECT, DONE, LOCKED);
  - a function that extracts the digit at a given index from a packed vector;
  - a function that checks all digits of a vector are legal.
- One sub-module, digit_value_counter: combinational, parameters NUM_DIGITS and DIGIT_W. Inputs are a packed vector and a value v; output is the CNT_W count of digits equal to v. Instantiated twice, once for the code and once for the guess.

Test Plan:
- Defaults. Load 0x1234; guess 0x1234 → result_valid at edge 14 after accept; exact=4, partial=0, solved=1, guess_ready stays 0.
- Code 0x1234; guess 0x4321 → exact=0, partial=4, attempts_used=1. Guess 0x1243 → exact=2, partial=2, attempts_used=2.
- Duplicates, code 0x1123. Guess 0x1111 → exact=2, partial=0. Guess 0x3311 → exact=0, partial=3.
- Guess 0x12A4 → guess_err=1 and result_valid at edge 1 after accept; attempts_used unchanged. Load code 0x9A00 → code_err pulse; stored code unchanged.
- MAX_ATTEMPTS=3. Three wrong guesses → locked_out=1 after the third result, guess_ready=0. code_load 0x0000 → locked_out=0, attempts_used=0, guess_ready=1.
- Both abort paths discard the in-flight guess:
  - rst_n low at edge 5 of an evaluation → all outputs 0, NO_CODE, no result_valid.
  - Separately, code_load during TOTAL → no result_valid; the next guess is scored against the new code.

Source files
------------

// File: rtl/code_guess_evaluator_pkg.sv
// code_break_pkg: shared state encoding and digit helpers for the code-break evaluator
package code_break_pkg;
  typedef enum logic [2:0] {NO_CODE, READY, EXACT, TOTAL, RESULT, REJECT, DONE, LOCKED} state_e;
  // Helpers take vectors zero-extended to MAX_VEC bits so one function serves any parameterisation.
  localparam int MAX_VEC = 256;
  localparam int MAX_DW = 32;
  function automatic logic [MAX_DW-1:0] get_digit(input logic [MAX_VEC-1:0] vec, input int idx, input int dw);
    logic [MAX_VEC-1:0] s;
    s = vec >> (idx * dw);
    return s[MAX_DW-1:0] & ((MAX_DW'(1) << dw) - MAX_DW'(1));
  endfunction
  function automatic logic all_legal(input logic [MAX_VEC-1:0] vec, input int n, input int dw, input int dmax);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) ok &= get_digit(vec, i, dw) <= MAX_DW'(dmax);
    return ok;
  endfunction
endpackage

// File: rtl/code_guess_evaluator_digit_value_counter.sv
// digit_value_counter: counts how many digits of a packed vector equal a given value
//   vec_i : packed digits, digit i at [i*DIGIT_W +: DIGIT_W]
//   v_i   : value to count
//   cnt_o : number of digits equal to v_i
module digit_value_counter
  import code_break_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W = 4
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   vec_i,
  input  logic [DIGIT_W-1:0]              v_i,
  output logic [$clog2(NUM_DIGITS+1)-1:0] cnt_o
);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < NUM_DIGITS; i++) cnt_o += CNT_W'(get_digit(MAX_VEC'(vec_i), i, DIGIT_W) == MAX_DW'(v_i));
  end
endmodule

// File: rtl/code_guess_evaluator.sv
// code_guess_evaluator: multi-cycle exact/partial scorer for code-break guesses with attempt tracking
//   code_load/code_in    : load a new defusal code (illegal codes pulse code_err)
//   guess_valid/ready/in : guess handshake, guess latched at the accept edge
//   result_valid         : one-cycle pulse, exact_cnt/partial_cnt/guess_err valid
//   solved/locked_out    : sticky status, cleared by a legal code load
//   attempts_used        : legal guesses scored since the last code load
module code_guess_evaluator
  import code_break_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter int DIGIT_MAX = 9,
  parameter int MAX_ATTEMPTS = 10,
  localparam int CNT_W = $clog2(NUM_DIGITS + 1),
  localparam int ATT_W = (MAX_ATTEMPTS == 0) ? 1 : $clog2(MAX_ATTEMPTS + 1),
  localparam int VEC_W = NUM_DIGITS * DIGIT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             code_load,
  input  logic [VEC_W-1:0] code_in,
  input  logic             guess_valid,
  output logic             guess_ready,
  input  logic [VEC_W-1:0] guess_in,
  output logic             result_valid,
  output logic [CNT_W-1:0] exact_cnt,
  output logic [CNT_W-1:0] partial_cnt,
  output logic             guess_err,
  output logic             code_err,
  output logic             solved,
  output logic             locked_out,
  output logic [ATT_W-1:0] attempts_used
);
  // idx_q walks digit positions in EXACT and digit values in TOTAL.
  localparam int IDX_W = $clog2(((NUM_DIGITS > DIGIT_MAX) ? NUM_DIGITS : DIGIT_MAX + 1) + 1);
  localparam logic [ATT_W-1:0] ATT_SAT = (MAX_ATTEMPTS == 0) ? '1 : ATT_W'(MAX_ATTEMPTS);
  state_e state_q, state_d;
  logic [VEC_W-1:0] code_q, code_d, guess_q, guess_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] exact_q, exact_d, total_q, total_d;
  logic [CNT_W-1:0] ex_cnt_q, ex_cnt_d, pa_cnt_q, pa_cnt_d;
  logic [ATT_W-1:0] att_q, att_d;
  logic rv_q, rv_d, gerr_q, gerr_d, cerr_q, cerr_d;
  logic solved_q, solved_d, locked_q, locked_d, ready_q, ready_d;
  logic code_ok, guess_ok, digit_eq, all_exact, lock_hit;
  logic [CNT_W-1:0] code_n, guess_n, min_n;
  assign code_ok = all_legal(MAX_VEC'(code_in), NUM_DIGITS, DIGIT_W, DIGIT_MAX);
  assign guess_ok = all_legal(MAX_VEC'(guess_in), NUM_DIGITS, DIGIT_W, DIGIT_MAX);
  assign digit_eq = get_digit(MAX_VEC'(code_q), int'(idx_q), DIGIT_W) == get_digit(MAX_VEC'(guess_q), int'(idx_q), DIGIT_W);
  assign min_n = (code_n < guess_n) ? code_n : guess_n;
  assign all_exact = exact_q == CNT_W'(NUM_DIGITS);
  assign lock_hit = (MAX_ATTEMPTS != 0) && (att_q == ATT_W'(MAX_ATTEMPTS));
  digit_value_counter #(.NUM_DIGITS(NUM_DIGITS), .DIGIT_W(DIGIT_W)) u_code_cnt (
    .vec_i(code_q),
    .v_i  (DIGIT_W'(idx_q)),
    .cnt_o(code_n)
  );
  digit_value_counter #(.NUM_DIGITS(NUM_DIGITS), .DIGIT_W(DIGIT_W)) u_guess_cnt (
    .vec_i(guess_q),
    .v_i  (DIGIT_W'(idx_q)),
    .cnt_o(guess_n)
  );
  always_comb begin
    state_d = state_q;
    code_d = code_q;
    guess_d = guess_q;
    idx_d = idx_q;
    exact_d = exact_q;
    total_d = total_q;
    ex_cnt_d = ex_cnt_q;
    pa_cnt_d = pa_cnt_q;
    att_d = att_q;
    rv_d = 1'b0;
    cerr_d = 1'b0;
    gerr_d = gerr_q;
    solved_d = solved_q;
    locked_d = locked_q;
    case (state_q)
      READY: if (guess_valid && !code_load) begin
        guess_d = guess_in;
        idx_d = '0;
        exact_d = '0;
        total_d = '0;
        gerr_d = guess_ok ? 1'b0 : gerr_q;
        att_d = (guess_ok && att_q != ATT_SAT) ? att_q + ATT_W'(1) : att_q;
        state_d = guess_ok ? EXACT : REJECT;
      end
      REJECT: begin
        rv_d = 1'b1;
        gerr_d = 1'b1;
        ex_cnt_d = '0;
        pa_cnt_d = '0;
        state_d = READY;
      end
      EXACT: begin
        exact_d = exact_q + CNT_W'(digit_eq);
        idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        state_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? TOTAL : EXACT;
      end
      TOTAL: begin
        total_d = total_q + min_n;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(DIGIT_MAX)) begin
          state_d = RESULT;
          rv_d = 1'b1;
          ex_cnt_d = exact_q;
          pa_cnt_d = total_d - exact_q;
        end
      end
      RESULT: begin
        solved_d = solved_q | all_exact;
        locked_d = locked_q | (!all_exact && lock_hit);
        state_d = all_exact ? DONE : (lock_hit ? LOCKED : READY);
      end
      default: ;
    endcase
    // A legal code load overrides everything, aborting any evaluation without a result.
    if (code_load) begin
      cerr_d = !code_ok;
      if (code_ok) begin
        code_d = code_in;
        state_d = READY;
        rv_d = 1'b0;
        gerr_d = 1'b0;
        solved_d = 1'b0;
        locked_d = 1'b0;
        att_d = '0;
      end
    end
    ready_d = state_d == READY;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NO_CODE;
      code_q <= '0;
      guess_q <= '0;
      idx_q <= '0;
      exact_q <= '0;
      total_q <= '0;
      ex_cnt_q <= '0;
      pa_cnt_q <= '0;
      att_q <= '0;
      rv_q <= 1'b0;
      cerr_q <= 1'b0;
      gerr_q <= 1'b0;
      solved_q <= 1'b0;
      locked_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      guess_q <= guess_d;
      idx_q <= idx_d;
      exact_q <= exact_d;
      total_q <= total_d;
      ex_cnt_q <= ex_cnt_d;
      pa_cnt_q <= pa_cnt_d;
      att_q <= att_d;
      rv_q <= rv_d;
      cerr_q <= cerr_d;
      gerr_q <= gerr_d;
      solved_q <= solved_d;
      locked_q <= locked_d;
      ready_q <= ready_d;
    end
  end
  assign guess_ready = ready_q;
  assign result_valid = rv_q;
  assign exact_cnt = ex_cnt_q;
  assign partial_cnt = pa_cnt_q;
  assign guess_err = gerr_q;
  assign code_err = cerr_q;
  assign solved = solved_q;
  assign locked_out = locked_q;
  assign attempts_used = att_q;
endmodule
